// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB-lite encodings used by the AHB initiator and
//               target blocks: the HTRANS transfer types and the fixed
//               HSIZE/HBURST values for single-word transfers.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD    = 3'b010;
  localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : ahb_lite_master
// Description : Single-transfer AHB-lite initiator. Turns a valid/ready
//               command stream into pipelined NONSEQ transfers, honours
//               hready wait states, and reports each completion (with read
//               data) on a one-cycle response strobe.
// Ports       : hclk/hresetn        - clock, synchronous active-low reset
//               cmd_*               - command stream (valid/ready handshake)
//               rsp_*               - completion strobe, direction, read data
//               busy                - address or data phase outstanding
//               htrans..hwdata      - AHB-lite initiator outputs
//               hready, hrdata      - AHB-lite target responses
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic [1:0]        htrans,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hsize,
  output logic [2:0]        hburst,
  output logic [DATA_W-1:0] hwdata,
  input  logic              hready,
  input  logic [DATA_W-1:0] hrdata
);

  // Address-phase stage
  logic              ap_valid_q, ap_valid_d;
  logic [ADDR_W-1:0] haddr_q,    haddr_d;
  logic              hwrite_q,   hwrite_d;
  logic [DATA_W-1:0] ap_wdata_q, ap_wdata_d;
  // Data-phase stage
  logic              dp_valid_q, dp_valid_d;
  logic              dp_write_q, dp_write_d;
  logic [DATA_W-1:0] hwdata_q,   hwdata_d;
  // Response registers
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_write_q, rsp_write_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic ap_adv;
  logic ap_load;
  logic dp_done;

  // An idle address phase may accept a command even during a wait state;
  // a NONSEQ address phase is only released when the bus is ready.
  assign cmd_ready = hready || !ap_valid_q;
  assign ap_adv    = ap_valid_q && hready;
  assign ap_load   = cmd_valid && cmd_ready;
  assign dp_done   = dp_valid_q && hready;

  always_comb begin
    ap_valid_d  = ap_valid_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    ap_wdata_d  = ap_wdata_q;
    dp_valid_d  = dp_valid_q;
    dp_write_d  = dp_write_q;
    hwdata_d    = hwdata_q;
    rsp_valid_d = 1'b0;
    rsp_write_d = rsp_write_q;
    rsp_rdata_d = rsp_rdata_q;

    // Data phase: retire the current transfer, refilled by an advancing AP.
    if (dp_done) begin
      dp_valid_d  = 1'b0;
      rsp_valid_d = 1'b1;
      rsp_write_d = dp_write_q;
      rsp_rdata_d = dp_write_q ? '0 : hrdata;
    end
    if (ap_adv) begin
      dp_valid_d = 1'b1;
      dp_write_d = hwrite_q;
      // Reads leave hwdata untouched so the bus does not toggle needlessly.
      if (hwrite_q) begin
        hwdata_d = ap_wdata_q;
      end
    end

    // Address phase: a new command wins over going idle; address and
    // direction are held when the stage empties.
    if (ap_load) begin
      ap_valid_d = 1'b1;
      haddr_d    = cmd_addr;
      hwrite_d   = cmd_write;
      ap_wdata_d = cmd_wdata;
    end else if (ap_adv) begin
      ap_valid_d = 1'b0;
    end
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      ap_valid_q  <= 1'b0;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      ap_wdata_q  <= '0;
      dp_valid_q  <= 1'b0;
      dp_write_q  <= 1'b0;
      hwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_valid_q  <= ap_valid_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      ap_wdata_q  <= ap_wdata_d;
      dp_valid_q  <= dp_valid_d;
      dp_write_q  <= dp_write_d;
      hwdata_q    <= hwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_write_q <= rsp_write_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign htrans    = ap_valid_q ? NONSEQ : IDLE;
  assign haddr     = haddr_q;
  assign hwrite    = hwrite_q;
  assign hsize     = HSIZE_WORD;
  assign hburst    = HBURST_SINGLE;
  assign hwdata    = hwdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = ap_valid_q || dp_valid_q;

endmodule : ahb_lite_master
`default_nettype wire

// File: tb/tb_ahb_lite_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_lite_master
// Description : Self-checking bench for ahb_lite_master. A cycle table of
//               inputs and hand-computed outputs covers reset, single
//               write/read, wait states with a pending command, loading
//               into an idle AP during a wait, and reset mid-transfer; a
//               hand-written loop covers ten back-to-back writes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master;

  logic        hclk;
  logic        hresetn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        busy;
  logic [1:0]  htrans;
  logic [7:0]  haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;

  int checks   = 0;
  int failures = 0;

  ahb_lite_master #(.ADDR_W(8), .DATA_W(32)) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .htrans    (htrans),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hburst    (hburst),
    .hwdata    (hwdata),
    .hready    (hready),
    .hrdata    (hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  typedef struct {
    logic        rst_n;
    logic        cv;
    logic        cw;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        hr;
    logic [31:0] hrd;
    logic        chk_rdy;
    logic        rdy;      // expected cmd_ready before the edge
    logic [1:0]  e_htrans; // expected registered outputs after the edge
    logic [7:0]  e_haddr;
    logic        e_hwrite;
    logic [31:0] e_hwdata;
    logic        e_rv;
    logic        e_rw;
    logic [31:0] e_rrd;
    logic        e_busy;
  } vec_t;

  function automatic vec_t mk(
    input logic rst_n, input logic cv, input logic cw, input logic [7:0] addr,
    input logic [31:0] wdata, input logic hr, input logic [31:0] hrd,
    input logic chk_rdy, input logic rdy, input logic [1:0] e_htrans,
    input logic [7:0] e_haddr, input logic e_hwrite, input logic [31:0] e_hwdata,
    input logic e_rv, input logic e_rw, input logic [31:0] e_rrd, input logic e_busy);
    vec_t v;
    v.rst_n = rst_n; v.cv = cv; v.cw = cw; v.addr = addr; v.wdata = wdata;
    v.hr = hr; v.hrd = hrd; v.chk_rdy = chk_rdy; v.rdy = rdy;
    v.e_htrans = e_htrans; v.e_haddr = e_haddr; v.e_hwrite = e_hwrite;
    v.e_hwdata = e_hwdata; v.e_rv = e_rv; v.e_rw = e_rw; v.e_rrd = e_rrd;
    v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst_n, input logic cv, input logic cw,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       input logic hr, input logic [31:0] hrd);
    hresetn   = rst_n;
    cmd_valid = cv;
    cmd_write = cw;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    hready    = hr;
    hrdata    = hrd;
  endtask

  vec_t vecs[$];

  initial begin
    int nonseq_run;
    int rsp_count;
    int rsp_run;
    string tag;

    drive(1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 1'b0, 32'h0);

    //        rst cv cw addr   wdata         hr hrdata        ck rdy ht  haddr hw hwdata        rv rw rrd           busy
    // reset with hready low
    vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        0, 32'h0,        0, 0, 0, 8'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 1, 0, 8'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    // single write
    vecs.push_back(mk(1, 1, 1, 8'h0d, 32'h5a5a5a5a, 1, 32'h0,        1, 1, 2, 8'h0d, 1, 32'h0,        0, 0, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h0d, 1, 32'h5a5a5a5a, 0, 0, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h0d, 1, 32'h5a5a5a5a, 1, 1, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h0d, 1, 32'h5a5a5a5a, 0, 1, 32'h0,        0));
    // single read: wdata must not reach hwdata, rdata sampled in data phase
    vecs.push_back(mk(1, 1, 0, 8'h03, 32'hdeadbeef, 1, 32'h0,        1, 1, 2, 8'h03, 0, 32'h5a5a5a5a, 0, 1, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h03, 0, 32'h5a5a5a5a, 0, 1, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h33,       1, 1, 0, 8'h03, 0, 32'h5a5a5a5a, 1, 0, 32'h33,       0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h77,       1, 1, 0, 8'h03, 0, 32'h5a5a5a5a, 0, 0, 32'h33,       0));
    // write A, read B loaded, then 3 wait cycles with command C pending
    vecs.push_back(mk(1, 1, 1, 8'h10, 32'h11111111, 1, 32'h0,        1, 1, 2, 8'h10, 1, 32'h5a5a5a5a, 0, 0, 32'h33,       1));
    vecs.push_back(mk(1, 1, 0, 8'h20, 32'h0,        1, 32'h0,        1, 1, 2, 8'h20, 0, 32'h11111111, 0, 0, 32'h33,       1));
    vecs.push_back(mk(1, 1, 1, 8'h30, 32'h33333333, 0, 32'h0,        1, 0, 2, 8'h20, 0, 32'h11111111, 0, 0, 32'h33,       1));
    vecs.push_back(mk(1, 1, 1, 8'h30, 32'h33333333, 0, 32'h0,        1, 0, 2, 8'h20, 0, 32'h11111111, 0, 0, 32'h33,       1));
    vecs.push_back(mk(1, 1, 1, 8'h30, 32'h33333333, 0, 32'h0,        1, 0, 2, 8'h20, 0, 32'h11111111, 0, 0, 32'h33,       1));
    vecs.push_back(mk(1, 1, 1, 8'h30, 32'h33333333, 1, 32'haaaa,     1, 1, 2, 8'h30, 1, 32'h11111111, 1, 1, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'hbbbb,     1, 1, 0, 8'h30, 1, 32'h33333333, 1, 0, 32'hbbbb,     1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h30, 1, 32'h33333333, 1, 1, 32'h0,        0));
    // load into an idle AP during a wait state
    vecs.push_back(mk(1, 1, 0, 8'h44, 32'h0,        0, 32'h0,        1, 1, 2, 8'h44, 0, 32'h33333333, 0, 1, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        0, 32'h0,        1, 0, 2, 8'h44, 0, 32'h33333333, 0, 1, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h44, 0, 32'h33333333, 0, 1, 32'h0,        1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h12345678, 1, 1, 0, 8'h44, 0, 32'h33333333, 1, 0, 32'h12345678, 0));
    // reset during a write data phase
    vecs.push_back(mk(1, 1, 1, 8'h55, 32'hcafef00d, 1, 32'h0,        1, 1, 2, 8'h55, 1, 32'h33333333, 0, 0, 32'h12345678, 1));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h55, 1, 32'hcafef00d, 0, 0, 32'h12345678, 1));
    vecs.push_back(mk(0, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h00, 0, 32'h0,        0, 0, 32'h0,        0));
    vecs.push_back(mk(1, 0, 0, 8'h00, 32'h0,        1, 32'h0,        1, 1, 0, 8'h00, 0, 32'h0,        0, 0, 32'h0,        0));

    foreach (vecs[i]) begin
      @(negedge hclk);
      drive(vecs[i].rst_n, vecs[i].cv, vecs[i].cw, vecs[i].addr, vecs[i].wdata,
            vecs[i].hr, vecs[i].hrd);
      #1;
      tag = $sformatf("v%0d", i);
      if (vecs[i].chk_rdy) chk({tag, " cmd_ready"}, {31'b0, cmd_ready}, {31'b0, vecs[i].rdy});
      @(posedge hclk);
      #1;
      chk({tag, " htrans"},    {30'b0, htrans},    {30'b0, vecs[i].e_htrans});
      chk({tag, " haddr"},     {24'b0, haddr},     {24'b0, vecs[i].e_haddr});
      chk({tag, " hwrite"},    {31'b0, hwrite},    {31'b0, vecs[i].e_hwrite});
      chk({tag, " hwdata"},    hwdata,             vecs[i].e_hwdata);
      chk({tag, " rsp_valid"}, {31'b0, rsp_valid}, {31'b0, vecs[i].e_rv});
      chk({tag, " rsp_write"}, {31'b0, rsp_write}, {31'b0, vecs[i].e_rw});
      chk({tag, " rsp_rdata"}, rsp_rdata,          vecs[i].e_rrd);
      chk({tag, " busy"},      {31'b0, busy},      {31'b0, vecs[i].e_busy});
    end

    chk("hsize",  {29'b0, hsize},  32'h2);
    chk("hburst", {29'b0, hburst}, 32'h0);

    // Ten back-to-back writes with hready high, then two drain cycles.
    nonseq_run = 0;
    rsp_count  = 0;
    rsp_run    = 0;
    for (int e = 0; e < 13; e++) begin
      @(negedge hclk);
      if (e < 10) drive(1'b1, 1'b1, 1'b1, 8'h99 - 8'(e), 32'hfff - 32'(e), 1'b1, 32'h0);
      else        drive(1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 1'b1, 32'h0);
      #1;
      if (e < 10) chk($sformatf("b2b%0d cmd_ready", e), {31'b0, cmd_ready}, 32'h1);
      @(posedge hclk);
      #1;
      if (htrans == 2'b10) nonseq_run++;
      if (rsp_valid) begin
        rsp_count++;
        rsp_run++;
      end
      if (e < 10) begin
        chk($sformatf("b2b%0d htrans", e), {30'b0, htrans}, 32'h2);
        chk($sformatf("b2b%0d haddr", e),  {24'b0, haddr},  {24'b0, 8'h99 - 8'(e)});
      end else begin
        chk($sformatf("b2b%0d htrans", e), {30'b0, htrans}, 32'h0);
      end
      if (e >= 1 && e <= 10)
        chk($sformatf("b2b%0d hwdata", e), hwdata, 32'hfff - 32'(e - 1));
      if (e >= 2 && e <= 11) begin
        chk($sformatf("b2b%0d rsp_valid", e), {31'b0, rsp_valid}, 32'h1);
        chk($sformatf("b2b%0d rsp_write", e), {31'b0, rsp_write}, 32'h1);
      end else begin
        chk($sformatf("b2b%0d rsp_valid", e), {31'b0, rsp_valid}, 32'h0);
      end
    end
    chk("b2b nonseq cycles", nonseq_run, 32'd10);
    chk("b2b rsp pulses",    rsp_count,  32'd10);
    chk("b2b rsp run",       rsp_run,    32'd10);
    chk("b2b busy drained",  {31'b0, busy}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_ahb_lite_master
`default_nettype wire

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
Synthesizable single-transfer AHB-lite initiator, the counterpart to ahb_slave. It converts a valid/ready command stream (addr, write, wdata) into pipelined NONSEQ transfers and honours hready wait states. Read data and write completions return on a one-cycle response strobe. It sits between local control logic and the AHB bus, and can drive ahb_slave directly.

Parameters:
ADDR_W, 8, width of haddr and cmd_addr
DATA_W, 32, width of hwdata, hrdata, cmd_wdata and rsp_rdata

Ports:
hclk  input  1  bus clock; all state updates on posedge
hresetn  input  1  reset, synchronous, active-low, sampled on posedge hclk
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted at posedge when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_W  transfer address
cmd_wdata  input  DATA_W  write data, captured with the command
rsp_valid  output  1  one-cycle completion strobe
rsp_write  output  1  direction of the completed transfer
rsp_rdata  output  DATA_W  read data; 0 for writes
busy  output  1  address or data phase outstanding
htrans  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
haddr  output  ADDR_W  address-phase address
hwrite  output  1  address-phase direction
hsize  output  3  constant 3'b010 (word)
hburst  output  3  constant 3'b000 (SINGLE)
hwdata  output  DATA_W  data-phase write data
hready  input  1  slave ready; a phase completes at posedge with hready=1
hrdata  input  DATA_W  slave read data, sampled when a read data phase completes

Behaviour:
- Reset (hresetn=0 at posedge): htrans=IDLE, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, internal ap_valid=0, dp_valid=0, busy=0. Reset overrides everything. An in-flight transfer is aborted with no rsp_valid.
- State consists of two pipeline stages:
  - Address phase (AP): ap_valid, haddr, hwrite, ap_wdata. htrans = ap_valid ? NONSEQ : IDLE.
  - Data phase (DP): dp_valid, dp_write, hwdata.
- cmd_ready = hready || !ap_valid. This is combinational and has no dependence on cmd_valid. An IDLE address phase may switch to NONSEQ during wait states. Once NONSEQ is driven, haddr, hwrite and ap_wdata are held stable until the AP completes at a posedge with hready=1.
- AP advance at posedge with ap_valid && hready:
  - dp_valid<=1, dp_write<=hwrite.
  - If hwrite=1, hwdata<=ap_wdata; if hwrite=0, hwdata holds its value.
- AP load at posedge with cmd_valid && cmd_ready:
  - ap_valid<=1, haddr<=cmd_addr, hwrite<=cmd_write, ap_wdata<=cmd_wdata.
  - If advancing but not loading: ap_valid<=0 (IDLE), haddr and hwrite hold.
- DP completion at posedge with dp_valid && hready:
  - Next cycle: rsp_valid=1, rsp_write=dp_write, rsp_rdata = dp_write ? 0 : hrdata.
  - dp_valid<=0 unless a simultaneous AP advance refills it.
- rsp_valid is high for exactly one cycle per completion and 0 otherwise. rsp_write and rsp_rdata hold between strobes.
- AP advance, AP load and DP completion may all occur on the same edge (back-to-back). Sustained throughput is 1 transfer/cycle while hready=1.
- Latency with hready=1 throughout: command accepted at edge E0, NONSEQ visible after E0, data phase after E1, rsp_valid high after E2.
- Wait state (hready=0): all AP and DP state holds, and rsp_valid=0 next cycle. Exception: loading into an IDLE AP is permitted.
- busy = ap_valid || dp_valid.
- The block never issues BUSY or SEQ, and has no hresp or error handling.

Decomposition:
- Shared package ahb_pkg holds:
  - htrans_t enum: IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11.
  - Constants HSIZE_WORD=3'b010 and HBURST_SINGLE=3'b000.
- The block is a single module with two pipeline register stages. No sub-module is warranted.

Test Plan:
- Reset with hready=0 -> htrans=0, haddr=0, hwrite=0, hwdata=0, rsp_valid=0, busy=0, and cmd_ready=1 (AP idle).
- Single write cmd (addr 8'h0d, wdata 32'h5a5a_5a5a) with hready=1 -> NONSEQ/haddr=0d/hwrite=1 one cycle, hwdata=5a5a_5a5a next cycle, rsp_valid pulse with rsp_write=1 the cycle after; when driving ahb_slave, uut.mem['h0d]==32'h5a5a_5a5a.
- Single read cmd (addr 8'h03) with hrdata=32'h0000_0033 in the data phase -> rsp_valid=1, rsp_write=0, rsp_rdata=32'h33 exactly 2 cycles after NONSEQ was first driven.
- Ten back-to-back writes (addr 'h99-i, data 'hfff-i, i=0..9) with hready=1 -> htrans=NONSEQ for 10 consecutive cycles, hwdata tracking one cycle behind, and exactly 10 rsp_valid pulses on consecutive cycles.
- hready held low 3 cycles during a write data phase while a second cmd is pending -> haddr, hwrite and hwdata stable, cmd_ready=0, no rsp_valid; both transfers then complete in order once hready=1.
- hresetn asserted in the middle of a write data phase -> no rsp_valid, all outputs at reset values the following cycle, and busy=0.
